// File: rtl/pipeline_pkg.sv
// Shared types for the five-stage pipeline hazard/sequencing controller.
package pipeline_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: does the load in EX feed a source of ID?
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rt_ex,
  output logic             lu
);
  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign lu = mem_read_ex && (rt_ex != '0) &&
              ((uses_rs && (rs_id == rt_ex)) || (uses_rt && (rt_id == rt_ex)));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: reset hold, load-use stall, EX redirect, memory freeze + watchdog.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] rt_EX,
  input  logic             branch_taken_EX,
  input  logic             Jump_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             pipe_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_err,
  output logic [1:0]       state
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
  output logic [15:0]      freeze_cnt
`endif
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t        state_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [WW-1:0] wait_cnt_reg;
  logic          lu;
  logic          redirect;
  logic          freeze;
  logic          frozen;

  load_use_detect u_lu (
    .rs_id       (rs_ID),
    .rt_id       (rt_ID),
    .uses_rs     (uses_rs_ID),
    .uses_rt     (uses_rt_ID),
    .mem_read_ex (MemRead_EX),
    .rt_ex       (rt_EX),
    .lu          (lu)
  );

  assign freeze   = mem_req_MEM && !mem_ready;
  assign redirect = branch_taken_EX || Jump_EX;
  assign state    = state_reg;

  // While waiting, only mem_ready matters; a pending redirect or lu is re-evaluated on release.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    pipe_en     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_err     = 1'b0;
    frozen      = 1'b0;
    case (state_reg)
      HOLD: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      RUN, MEM_WAIT: begin
        if ((state_reg == MEM_WAIT) ? !mem_ready : freeze) begin
          frozen = 1'b1;
        end else if (redirect) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          pipe_en     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu) begin
          pipe_en     = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          pipe_en  = 1'b1;
        end
      end
      ERROR: mem_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) state_reg <= RUN;
          else hold_cnt_reg <= hold_cnt_reg + HW'(1);
        end
        RUN: begin
          if (frozen) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          if (!frozen) state_reg <= RUN;
          else if (wait_cnt_reg == WAIT_LAST) state_reg <= ERROR;
          else wait_cnt_reg <= wait_cnt_reg + WW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_CTRL_STATS_EN
  logic       run_like;
  logic [2:0] stat_hit;

  // Each event is counted only when it is the condition that actually drives the controls.
  assign run_like = (state_reg == RUN) || (state_reg == MEM_WAIT);
  assign stat_hit = {frozen,
                     run_like && !frozen && redirect,
                     run_like && !frozen && !redirect && lu};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_reg <= '0;
      else if (stat_hit[gi] && (cnt_reg != 16'hFFFF)) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign stall_cnt  = g_stat[0].cnt_reg;
  assign flush_cnt  = g_stat[1].cnt_reg;
  assign freeze_cnt = g_stat[2].cnt_reg;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic vs a cycle-count model.
// Stats checks are compiled in when HAZARD_CTRL_STATS_EN is defined.
module tb_pipeline_ctrl;
  localparam int HOLD_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs_ID = '0, rt_ID = '0, rt_EX = '0;
  logic       uses_rs_ID = 1'b0, uses_rt_ID = 1'b0, MemRead_EX = 1'b0;
  logic       branch_taken_EX = 1'b0, Jump_EX = 1'b0, mem_req_MEM = 1'b0, mem_ready = 1'b0;
  logic       pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, mem_err;
  logic [1:0] state;
`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   verbose = 1'b1;

  // Model: cycles since reset release, length of the current frozen run, sticky error.
  int   m_cycle, m_frozen, m_stall, m_flush, m_freeze;
  bit   m_err;
  logic [7:0] exp_vec;
  bit   exp_frz, exp_stall, exp_flush;
  logic obs_err;

  pipeline_ctrl #(.HOLD_CYCLES(HOLD_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EX(MemRead_EX), .rt_EX(rt_EX),
    .branch_taken_EX(branch_taken_EX), .Jump_EX(Jump_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .pipe_en(pipe_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_err(mem_err), .state(state)
`ifdef HAZARD_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cycle = 0; m_frozen = 0; m_err = 1'b0;
    m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // Expected controls packed as {pc,ifid,pipe,flush_ifid,flush_idex,err,state[1:0]}.
  task automatic compute();
    bit lu_hit, redir, frz, in_wait;
    logic [1:0] st;
    lu_hit = MemRead_EX && (rt_EX != 0) &&
             ((uses_rs_ID && rs_ID == rt_EX) || (uses_rt_ID && rt_ID == rt_EX));
    redir = branch_taken_EX || Jump_EX;
    exp_frz = 1'b0; exp_stall = 1'b0; exp_flush = 1'b0;
    if (!rst_n || m_cycle < HOLD_CYCLES) begin
      exp_vec = 8'b000_11_0_00;
    end else if (m_err) begin
      exp_vec = 8'b000_00_1_11;
    end else begin
      in_wait = (m_frozen > 0);
      st = in_wait ? 2'd2 : 2'd1;
      frz = in_wait ? !mem_ready : (mem_req_MEM && !mem_ready);
      if (frz) begin
        exp_vec = {6'b000_00_0, st}; exp_frz = 1'b1;
      end else if (redir) begin
        exp_vec = {6'b111_11_0, st}; exp_flush = 1'b1;
      end else if (lu_hit) begin
        exp_vec = {6'b001_01_0, st}; exp_stall = 1'b1;
      end else begin
        exp_vec = {6'b111_00_0, st};
      end
    end
  endtask

  task automatic update();
    if (m_cycle < HOLD_CYCLES) m_cycle++;
    else if (!m_err) begin
      if (exp_frz) begin
        m_frozen++;
        if (m_frozen == MEM_TIMEOUT + 1) m_err = 1'b1;
      end else begin
        m_frozen = 0;
      end
    end
    if (exp_frz && m_freeze < 65535) m_freeze++;
    if (exp_flush && m_flush < 65535) m_flush++;
    if (exp_stall && m_stall < 65535) m_stall++;
  endtask

  task automatic check(input string tag);
    logic [7:0] obs;
    compute();
    obs = {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, mem_err, state};
    obs_err = mem_err;
    checks++;
    assert (obs === exp_vec) else begin
      errors++;
      $error("FAIL %s {pc,ifid,pipe,fl_ifid,fl_idex,err,state} observed=%b expected=%b", tag, obs, exp_vec);
    end
`ifdef HAZARD_CTRL_STATS_EN
    checks++;
    assert (stall_cnt === 16'(m_stall)) else begin
      errors++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, m_stall);
    end
    checks++;
    assert (flush_cnt === 16'(m_flush)) else begin
      errors++; $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, m_flush);
    end
    checks++;
    assert (freeze_cnt === 16'(m_freeze)) else begin
      errors++; $error("FAIL %s freeze_cnt observed=%0d expected=%0d", tag, freeze_cnt, m_freeze);
    end
`endif
    if (verbose) $display("%-12s ctrl=%b state=%0d", tag, obs, state);
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    update();
    #1;
  endtask

  // Reset is dropped mid-cycle so the asynchronous response is observed before any edge.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_async");
    @(posedge clk);
    #1;
    check("reset_held");
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    rs_ID = '0; rt_ID = '0; rt_EX = '0;
    uses_rs_ID = 1'b0; uses_rt_ID = 1'b0; MemRead_EX = 1'b0;
    branch_taken_EX = 1'b0; Jump_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    int first_err;
    idle_inputs();
    apply_reset();
    repeat (HOLD_CYCLES) tick("hold");
    tick("run_idle");

    // Load-use: one stall, then the load moves on.
    MemRead_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8; uses_rs_ID = 1'b1;
    tick("lu_stall");
    MemRead_EX = 1'b0;
    tick("lu_after");
    MemRead_EX = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0;
    tick("lu_r0");
    rt_EX = 5'd5; rt_ID = 5'd5; uses_rs_ID = 1'b0; uses_rt_ID = 1'b1;
    tick("lu_rt");

    // Redirect beats load-use.
    rt_EX = 5'd8; rs_ID = 5'd8; uses_rs_ID = 1'b1; branch_taken_EX = 1'b1;
    tick("redir_lu");
    idle_inputs(); Jump_EX = 1'b1;
    tick("jump");
    idle_inputs();
    tick("run_idle");

    // Three-cycle miss, then release.
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    repeat (3) tick("miss");
    mem_ready = 1'b1;
    tick("miss_release");
    idle_inputs();
    tick("run_idle");

    // Redirect held across a freeze is applied on release.
    mem_req_MEM = 1'b1; branch_taken_EX = 1'b1;
    repeat (2) tick("redir_frz");
    mem_ready = 1'b1;
    tick("redir_rel");
    idle_inputs();
    tick("run_idle");

    // Watchdog: never-ready access.
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    first_err = -1;
    for (int i = 0; i < 20; i++) begin
      tick("timeout");
      if (obs_err === 1'b1 && first_err < 0) first_err = i;
    end
    checks++;
    assert (first_err == MEM_TIMEOUT + 1) else begin
      errors++;
      $error("FAIL timeout_cycle observed=%0d expected=%0d", first_err, MEM_TIMEOUT + 1);
    end
    mem_ready = 1'b1;
    repeat (2) tick("err_sticky");
    idle_inputs();
    apply_reset();
    repeat (HOLD_CYCLES) tick("hold");

    // Reset in the middle of a wait.
    mem_req_MEM = 1'b1; mem_ready = 1'b0;
    repeat (3) tick("wait");
    apply_reset();
    idle_inputs();
    repeat (HOLD_CYCLES + 1) tick("rewake");

    // Randomized traffic with occasional resets.
    verbose = 1'b0;
    for (int i = 0; i < 800; i++) begin
      mem_req_MEM     = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 1) == 0);
      branch_taken_EX = ($urandom_range(0, 7) == 0);
      Jump_EX         = ($urandom_range(0, 11) == 0);
      MemRead_EX      = ($urandom_range(0, 1) == 0);
      uses_rs_ID      = ($urandom_range(0, 1) == 0);
      uses_rt_ID      = ($urandom_range(0, 1) == 0);
      rs_ID = 5'($urandom_range(0, 3));
      rt_ID = 5'($urandom_range(0, 3));
      rt_EX = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) apply_reset();
      tick("random");
    end

`ifdef HAZARD_CTRL_STATS_EN
    // Saturation of the stall counter under a permanent load-use.
    idle_inputs();
    apply_reset();
    MemRead_EX = 1'b1; rt_EX = 5'd3; rs_ID = 5'd3; uses_rs_ID = 1'b1;
    repeat (65540) tick("sat");
    @(negedge clk);
    checks++;
    assert (stall_cnt === 16'hFFFF) else begin
      errors++; $error("FAIL stall_sat observed=%h expected=ffff", stall_cnt);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the write-enables and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles four conditions: post-reset flush hold, load-use stalls, branch/jump redirects resolved in EX, and whole-pipeline freeze on multi-cycle data-memory accesses, with a watchdog timeout on those accesses.

## Interface
- HOLD_CYCLES, 2: cycles the pipeline stays flushed after reset release; must be ≥1
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before error; must be ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- rs_ID, rt_ID  in  5  source register numbers of the instruction in ID
- uses_rs_ID, uses_rt_ID  in  1  ID instruction actually reads rs / rt
- MemRead_EX  in  1  instruction in EX is a load
- rt_EX  in  5  destination of the load in EX
- branch_taken_EX  in  1  conditional branch in EX resolved taken (BranchEQ&zero | BranchNE&!zero, computed outside)
- Jump_EX  in  1  jump in EX
- mem_req_MEM  in  1  load/store occupying MEM
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, pipe_en  out  1  PC, IF/ID and (ID/EX, EX/MEM, MEM/WB) write enables
- if_id_flush, id_ex_flush  out  1  load zero (bubble) into IF/ID / ID/EX on the next edge
- mem_err  out  1  sticky watchdog error
- state  out  2  current FSM state

## Operation
- FSM states: HOLD=0, RUN=1, MEM_WAIT=2, ERROR=3.
- Outputs are Mealy: combinational from the registered state and the current inputs. Only state, hold_cnt and wait_cnt are registered.
- Terms:
  - freeze = mem_req_MEM & !mem_ready
  - redirect = branch_taken_EX | Jump_EX
  - lu = MemRead_EX & rt_EX≠0 & ((uses_rs_ID & rs_ID==rt_EX) | (uses_rt_ID & rt_ID==rt_EX))
- HOLD:
  - Outputs: pc_en=if_id_en=pipe_en=0, if_id_flush=id_ex_flush=1, mem_err=0.
  - hold_cnt increments each cycle; at HOLD_CYCLES-1 go to RUN.
- RUN, evaluated in priority order:
  - freeze: all enables 0, no flushes, go to MEM_WAIT with wait_cnt=0.
  - redirect: pc_en=if_id_en=pipe_en=1, if_id_flush=id_ex_flush=1 (PC loads the target supplied externally).
  - lu: pc_en=if_id_en=0, pipe_en=1, id_ex_flush=1 (one bubble per cycle lu holds).
  - otherwise: all enables 1, no flushes.
- MEM_WAIT:
  - mem_ready=0: outputs as freeze. If wait_cnt==MEM_TIMEOUT-1, go to ERROR; otherwise wait_cnt++.
  - mem_ready=1: apply the RUN rules with freeze=0 that same cycle, then go to RUN.
- ERROR: all enables 0, no flushes, mem_err=1. Exit only via rst_n.
- Redirect and lu together: redirect wins, because the stalling ID instruction is squashed.
- A redirect or lu arriving during freeze is ignored. It stays in place and is re-evaluated after release.
- rst_n low at any time, including mid-wait: go to HOLD immediately and clear all counters.

## Timing
- Reset values: state=HOLD, hold_cnt=0, wait_cnt=0. Outputs follow HOLD: pc_en=0, if_id_en=0, pipe_en=0, if_id_flush=1, id_ex_flush=1, mem_err=0.
- First RUN cycle is HOLD_CYCLES cycles after the first rising edge with rst_n high.
- Zero-cycle latency from inputs to controls, since all controls are combinational.
- Load-use costs exactly 1 stall cycle when the load advances normally.
- Redirect costs 2 squashed instructions.
- Memory miss of n cycles (mem_ready rising on the n-th MEM_WAIT cycle) freezes the pipeline for n cycles total, counting the first RUN cycle.
- Never-ready access: mem_err rises MEM_TIMEOUT+1 cycles after the first frozen cycle.

## Configuration
- HAZARD_CTRL_STATS_EN defined:
  - Adds outputs stall_cnt[15:0], flush_cnt[15:0] and freeze_cnt[15:0].
  - Each is a saturating count of lu-stall cycles, redirect cycles and freeze cycles respectively.
  - All reset to 0.
  - Each counter counts only the cycles in which its condition actually controls the outputs.
- Undefined: these ports and counters do not exist, and control behaviour is identical.

## Structure
- Shared package pipeline_pkg: state enum typedef (HOLD/RUN/MEM_WAIT/ERROR, 2-bit encoding above) and the register-number width constant (5).
- One sub-module, load_use_detect: purely combinational lu comparator, reused later for forwarding checks.

## Test plan
- Reset release, HOLD_CYCLES=2 → flushes high and enables low for 2 cycles, then state=RUN with all enables 1.
- MemRead_EX=1, rt_EX=8, rs_ID=8, uses_rs_ID=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Same with rt_EX=0 → no stall.
- branch_taken_EX=1 together with an lu condition → if_id_flush=id_ex_flush=1, pc_en=1, no stall.
- mem_req_MEM=1, mem_ready low 3 cycles then high → enables 0 for exactly 3 cycles; the 4th cycle is normal with state returning to RUN.
- mem_ready never rises, MEM_TIMEOUT=16 → mem_err=1 on the 18th cycle after the first frozen cycle, sticky until rst_n pulse.
- rst_n dropped in MEM_WAIT → immediate HOLD outputs. With HAZARD_CTRL_STATS_EN, counters are 0 after reset and saturate at 0xFFFF.
